// File: rtl/spmv_fp_mul_pipe.sv
// spmv_fp_mul_pipe
//   Three-stage pipelined floating-point multiplier for the SpMV datapath
//   (matrix value x vector element). Exponent/mantissa widths are parameters.
//   Rounding is round-to-nearest-even. Subnormal inputs are flushed to zero,
//   and the block never produces a subnormal result. NaN, infinity and zero
//   operands are handled as special cases, and four exception flags are
//   reported. A sideband tag travels alongside each operand pair.
//   Flow control is valid/ready. Empty stages are filled first, so bubbles
//   collapse.
//
// Ports
//   i_clk     clock, rising edge
//   i_rst     synchronous active-high reset; discards every in-flight pair
//   i_valid   operand pair valid
//   o_ready   pair accepted this cycle when i_valid && o_ready
//   i_a, i_b  operands (W = 1+EXP_W+MAN_W bits)
//   i_tag     sideband tag carried with the pair
//   o_valid   result valid (registered)
//   i_ready   result consumed this cycle when o_valid && i_ready
//   o_result  product (registered, held while stalled)
//   o_tag     tag of the pair that produced o_result
//   o_flags   {invalid, overflow, underflow, inexact}
module spmv_fp_mul_pipe #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [EXP_W+MAN_W:0] i_a,
    input  logic [EXP_W+MAN_W:0] i_b,
    input  logic [TAG_W-1:0]     i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [EXP_W+MAN_W:0] o_result,
    output logic [TAG_W-1:0]     o_tag,
    output logic [3:0]           o_flags
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;
    localparam int XW = EXP_W + 2;
    localparam logic signed [XW-1:0] BIAS_X  = XW'((32'd1 << (EXP_W - 1)) - 32'd1);
    localparam logic signed [XW-1:0] EXP_TOP = XW'((32'd1 << EXP_W) - 32'd1);
    localparam logic signed [XW-1:0] ONE_X   = XW'(32'd1);
    localparam logic signed [XW-1:0] ZERO_X  = XW'(32'd0);

    // Result class decided in stage 1; only K_NORM goes through rounding/range logic.
    typedef enum logic [1:0] {
        K_NORM = 2'd0,
        K_ZERO = 2'd1,
        K_INF  = 2'd2,
        K_NAN  = 2'd3
    } kind_e;

    // Returns {invalid, kind}. NaN operands win over inf x 0. Only inf x 0 raises invalid.
    // A zero exponent field covers both zero and subnormal, so subnormals are flushed to zero.
    function automatic logic [2:0] classify(
        input logic [EXP_W-1:0] ea,
        input logic [MAN_W-1:0] ma,
        input logic [EXP_W-1:0] eb,
        input logic [MAN_W-1:0] mb
    );
        logic a_top, b_top, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
        logic [2:0] r;
        a_top  = (ea == {EXP_W{1'b1}});
        b_top  = (eb == {EXP_W{1'b1}});
        a_zero = (ea == {EXP_W{1'b0}});
        b_zero = (eb == {EXP_W{1'b0}});
        a_nan  = a_top && (ma != {MAN_W{1'b0}});
        b_nan  = b_top && (mb != {MAN_W{1'b0}});
        a_inf  = a_top && (ma == {MAN_W{1'b0}});
        b_inf  = b_top && (mb == {MAN_W{1'b0}});
        if (a_nan || b_nan) begin
            r = {1'b0, K_NAN};
        end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
            r = {1'b1, K_NAN};
        end else if (a_inf || b_inf) begin
            r = {1'b0, K_INF};
        end else if (a_zero || b_zero) begin
            r = {1'b0, K_ZERO};
        end else begin
            r = {1'b0, K_NORM};
        end
        return r;
    endfunction

    // ---------------- handshake ----------------
    logic en1_s, en2_s, en3_s;
    logic out_v_q;
    logic s1_v_q, s2_v_q;

    // A stage loads when it is empty or its occupant moves on this cycle.
    assign en3_s   = !out_v_q || i_ready;
    assign en2_s   = !s2_v_q || en3_s;
    assign en1_s   = !s1_v_q || en2_s;
    assign o_ready = en1_s;

    // ---------------- stage 1 ----------------
    logic [EXP_W-1:0]        ea_s, eb_s;
    logic [MAN_W-1:0]        ma_s, mb_s;
    logic [PW-1:0]           sig_a_s, sig_b_s;
    logic [2:0]              cls_s;
    logic                    s1_sign_d, s1_sign_q;
    logic signed [XW-1:0]    s1_exp_d, s1_exp_q;
    logic [PW-1:0]           s1_prod_d, s1_prod_q;
    kind_e                   s1_kind_d, s1_kind_q;
    logic                    s1_inv_d, s1_inv_q;
    logic [TAG_W-1:0]        s1_tag_q;

    assign ea_s    = i_a[W-2:MAN_W];
    assign eb_s    = i_b[W-2:MAN_W];
    assign ma_s    = i_a[MAN_W-1:0];
    assign mb_s    = i_b[MAN_W-1:0];
    assign sig_a_s = {{(MAN_W + 1){1'b0}}, 1'b1, ma_s};
    assign sig_b_s = {{(MAN_W + 1){1'b0}}, 1'b1, mb_s};

    // Stage 1 next-state: sign, biased exponent sum, full significand product, class.
    always_comb begin
        cls_s     = classify(ea_s, ma_s, eb_s, mb_s);
        s1_sign_d = i_a[W-1] ^ i_b[W-1];
        s1_exp_d  = $signed({2'b00, ea_s}) + $signed({2'b00, eb_s}) - BIAS_X;
        s1_prod_d = sig_a_s * sig_b_s;
        s1_kind_d = kind_e'(cls_s[1:0]);
        s1_inv_d  = cls_s[2];
    end

    // Stage 1 register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_v_q    <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_exp_q  <= ZERO_X;
            s1_prod_q <= {PW{1'b0}};
            s1_kind_q <= K_ZERO;
            s1_inv_q  <= 1'b0;
            s1_tag_q  <= {TAG_W{1'b0}};
        end else if (en1_s) begin
            s1_v_q <= i_valid;
            if (i_valid) begin
                s1_sign_q <= s1_sign_d;
                s1_exp_q  <= s1_exp_d;
                s1_prod_q <= s1_prod_d;
                s1_kind_q <= s1_kind_d;
                s1_inv_q  <= s1_inv_d;
                s1_tag_q  <= i_tag;
            end
        end
    end

    // ---------------- stage 2 ----------------
    logic signed [XW-1:0] s2_exp_d, s2_exp_q;
    logic [MAN_W-1:0]     s2_frac_d, s2_frac_q;
    logic                 s2_guard_d, s2_guard_q;
    logic                 s2_sticky_d, s2_sticky_q;
    logic                 s2_sign_q, s2_inv_q;
    kind_e                s2_kind_q;
    logic [TAG_W-1:0]     s2_tag_q;

    // Stage 2 next-state: the product of two [1,2) significands lies in [1,4).
    // If it is 2 or more, drop one more bit into the sticky bit and bump the exponent.
    always_comb begin
        if (s1_prod_q[PW-1]) begin
            s2_frac_d   = s1_prod_q[2*MAN_W:MAN_W+1];
            s2_guard_d  = s1_prod_q[MAN_W];
            s2_sticky_d = |s1_prod_q[MAN_W-1:0];
            s2_exp_d    = s1_exp_q + ONE_X;
        end else begin
            s2_frac_d   = s1_prod_q[2*MAN_W-1:MAN_W];
            s2_guard_d  = s1_prod_q[MAN_W-1];
            s2_sticky_d = |s1_prod_q[MAN_W-2:0];
            s2_exp_d    = s1_exp_q;
        end
    end

    // Stage 2 register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s2_v_q      <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= ZERO_X;
            s2_frac_q   <= {MAN_W{1'b0}};
            s2_guard_q  <= 1'b0;
            s2_sticky_q <= 1'b0;
            s2_kind_q   <= K_ZERO;
            s2_inv_q    <= 1'b0;
            s2_tag_q    <= {TAG_W{1'b0}};
        end else if (en2_s) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_sign_q   <= s1_sign_q;
                s2_exp_q    <= s2_exp_d;
                s2_frac_q   <= s2_frac_d;
                s2_guard_q  <= s2_guard_d;
                s2_sticky_q <= s2_sticky_d;
                s2_kind_q   <= s1_kind_q;
                s2_inv_q    <= s1_inv_q;
                s2_tag_q    <= s1_tag_q;
            end
        end
    end

    // ---------------- stage 3 ----------------
    logic                 round_up_s, carry_s;
    logic [MAN_W-1:0]     frac_rnd_s;
    logic signed [XW-1:0] exp_r_s;
    logic [W-1:0]         res_d, res_q;
    logic [3:0]           flags_d, flags_q;
    logic [TAG_W-1:0]     tag_q;

    // Stage 3 next-state: round to nearest even, then range check and pack.
    // On a mantissa carry-out the fraction wraps to zero and the exponent steps up by one.
    always_comb begin
        round_up_s            = s2_guard_q && (s2_sticky_q || s2_frac_q[0]);
        {carry_s, frac_rnd_s} = {1'b0, s2_frac_q} + {{MAN_W{1'b0}}, round_up_s};
        if (carry_s) begin
            exp_r_s = s2_exp_q + ONE_X;
        end else begin
            exp_r_s = s2_exp_q;
        end
        res_d   = {W{1'b0}};
        flags_d = 4'b0000;
        case (s2_kind_q)
            K_NAN: begin
                res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};
                flags_d = {s2_inv_q, 3'b000};
            end
            K_INF: begin
                res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                flags_d = 4'b0000;
            end
            K_ZERO: begin
                res_d   = {s2_sign_q, {(W - 1){1'b0}}};
                flags_d = 4'b0000;
            end
            K_NORM: begin
                if (exp_r_s >= EXP_TOP) begin
                    res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    flags_d = 4'b0101;
                end else if (exp_r_s <= ZERO_X) begin
                    res_d   = {s2_sign_q, {(W - 1){1'b0}}};
                    flags_d = 4'b0011;
                end else begin
                    res_d   = {s2_sign_q, exp_r_s[EXP_W-1:0], frac_rnd_s};
                    flags_d = {3'b000, s2_guard_q | s2_sticky_q};
                end
            end
            default: begin
                res_d   = {W{1'b0}};
                flags_d = 4'b0000;
            end
        endcase
    end

    // Output register; it holds its contents while downstream stalls.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_v_q <= 1'b0;
            res_q   <= {W{1'b0}};
            flags_q <= 4'b0000;
            tag_q   <= {TAG_W{1'b0}};
        end else if (en3_s) begin
            out_v_q <= s2_v_q;
            if (s2_v_q) begin
                res_q   <= res_d;
                flags_q <= flags_d;
                tag_q   <= s2_tag_q;
            end
        end
    end

    assign o_valid  = out_v_q;
    assign o_result = res_q;
    assign o_tag    = tag_q;
    assign o_flags  = flags_q;

endmodule
